// File: rtl/attn_score_feeder_pkg.sv
// Shared definitions for the attention score feeder: Q8.7 score format,
// saturation bounds, the masked-score marker and the FSM state encoding.
package attn_score_feeder_pkg;

  localparam int SCORE_W    = 16;
  localparam int SCORE_FRAC = 7;

  localparam logic signed [SCORE_W-1:0] MASK_VAL  = 16'sh8000;
  localparam logic signed [SCORE_W-1:0] SCORE_MAX = 16'sh7fff;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/attn_score_feeder_score_scale_sat.sv
// Combinational score datapath: scale a raw dot product by an unsigned Q0.16
// factor, round half toward +inf into Q8.7, saturate to 16 bits, and replace
// the result with the mask marker when the position is masked.
module score_scale_sat
  import attn_score_feeder_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int ACC_FRAC  = 0,
  parameter int SCALE_Q16 = 8192,
  parameter int OUT_FRAC  = SCORE_FRAC
) (
  input  logic signed [ACC_W-1:0]   s_data_i,
  input  logic                      mask_i,
  output logic signed [SCORE_W-1:0] score_o
);

  // Shift that lands the product's binary point on the output's; must be >= 1.
  localparam int SH = ACC_FRAC + 16 - OUT_FRAC;
  localparam int PW = ACC_W + 17;

  localparam logic signed [16:0] SCALE  = 17'(SCALE_Q16);
  localparam logic signed [PW:0] HALF   = {{PW{1'b0}}, 1'b1} << (SH - 1);
  localparam logic signed [PW:0] SAT_HI = (PW + 1)'(SCORE_MAX);
  localparam logic signed [PW:0] SAT_LO = (PW + 1)'(SCORE_MIN);

  logic signed [PW-1:0]      prod;
  logic signed [PW:0]        biased;
  logic signed [PW:0]        rounded;
  logic signed [SCORE_W-1:0] sat;

  // One extra bit of headroom keeps the rounding bias from overflowing.
  always_comb begin
    prod    = PW'(s_data_i) * PW'(SCALE);
    biased  = (PW + 1)'(prod) + HALF;
    rounded = biased >>> SH;
    if (rounded > SAT_HI) begin
      sat = SCORE_MAX;
    end else if (rounded < SAT_LO) begin
      sat = SCORE_MIN;
    end else begin
      sat = rounded[SCORE_W-1:0];
    end
    score_o = mask_i ? MASK_VAL : sat;
  end

endmodule

// File: rtl/attn_score_feeder.sv
// Feeds one row of scaled, rounded, saturated and optionally causally masked
// Q8.7 scores into the softmax load port: a start pulse, then N beats under
// in_ready back-pressure, then a done pulse. Two register stages, one score
// per cycle when not stalled.
module attn_score_feeder
  import attn_score_feeder_pkg::*;
#(
  parameter int N         = 256,
  parameter int ACC_W     = 32,
  parameter int ACC_FRAC  = 0,
  parameter int SCALE_Q16 = 8192,
  parameter int OUT_W     = SCORE_W,
  parameter int OUT_FRAC  = SCORE_FRAC,
  parameter int CAUSAL    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    row_start_i,
  input  logic [$clog2(N)-1:0]    q_pos_i,
  input  logic                    s_valid_i,
  input  logic signed [ACC_W-1:0] s_data_i,
  output logic                    s_ready_o,
  output logic                    start_o,
  output logic                    out_valid_o,
  output logic [OUT_W-1:0]        out_data_o,
  input  logic                    in_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int QW = $clog2(N);
  localparam int CW = QW + 1;

  state_t state_q, state_d;
  logic [QW-1:0] q_pos_q, q_pos_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          p1_valid_q, p1_valid_d;
  logic          p1_mask_q, p1_mask_d;
  logic signed [ACC_W-1:0] p1_data_q, p1_data_d;
  logic          out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic adv_en;
  logic s_accept;
  logic out_beat;
  logic mask_now;
  logic signed [SCORE_W-1:0] score;

  // Whole pipeline advances together unless a valid output is being held.
  always_comb begin
    adv_en    = !out_valid_q || in_ready_i;
    s_ready_o = (state_q == S_STREAM) && adv_en && (in_cnt_q < CW'(N));
    s_accept  = s_valid_i && s_ready_o;
    out_beat  = out_valid_q && in_ready_i;
    mask_now  = (CAUSAL != 0) && (in_cnt_q > {1'b0, q_pos_q});
  end

  score_scale_sat #(
    .ACC_W    (ACC_W),
    .ACC_FRAC (ACC_FRAC),
    .SCALE_Q16(SCALE_Q16),
    .OUT_FRAC (OUT_FRAC)
  ) u_scale (
    .s_data_i(p1_data_q),
    .mask_i  (p1_mask_q),
    .score_o (score)
  );

  // Next-state logic: row FSM, beat counters and the two pipeline stages.
  always_comb begin
    state_d     = state_q;
    q_pos_d     = q_pos_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    p1_valid_d  = p1_valid_q;
    p1_data_d   = p1_data_q;
    p1_mask_d   = p1_mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (s_accept) begin
      in_cnt_d = in_cnt_q + CW'(1);
    end
    if (out_beat) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end

    if (adv_en) begin
      p1_valid_d = s_accept;
      if (s_accept) begin
        p1_data_d = s_data_i;
        p1_mask_d = mask_now;
      end
      out_valid_d = p1_valid_q;
      if (p1_valid_q) begin
        out_data_d = OUT_W'(score);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (row_start_i) begin
          q_pos_d   = q_pos_i;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          start_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_ready_i) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_beat && (out_cnt_q == CW'(N - 1))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; a reset mid-row simply drops the row without done.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      q_pos_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_data_q   <= '0;
      p1_mask_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      q_pos_q     <= q_pos_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      p1_valid_q  <= p1_valid_d;
      p1_data_q   <= p1_data_d;
      p1_mask_q   <= p1_mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign start_o     = start_q;
  assign done_o      = done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
